// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-network datapath blocks.
//   PSUM_W   : width of one PE-array partial sum (signed)
//   PSUM_MIN : most negative legal partial sum
//   PSUM_MAX : most positive legal partial sum
//   buf_state_t : occupancy encoding of the 2-entry output buffer
package bnn_pkg;

  localparam int PSUM_W   = 5;
  localparam int PSUM_MIN = -9;
  localparam int PSUM_MAX = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/xnor_out_fifo.sv
// Two-entry register FIFO with an explicit occupancy FSM.
// The head entry is held in a register and drives dout directly.
// A push into a full FIFO with no pop in the same cycle is discarded.
// The parent block detects that case from full and ready.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset, empties the FIFO
//   clear : synchronous flush, same effect as rst
//   push  : write din this cycle
//   din   : entry to write
//   ready : consumer accepts the head entry (pop = valid && ready)
//   valid : head entry is valid
//   full  : both entries occupied
//   dout  : head entry
module xnor_out_fifo
  import bnn_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  buf_state_t       state, state_next;
  logic [WIDTH-1:0] head, tail;
  logic             pop;
  logic             load_head, head_from_tail, load_tail;

  assign valid = (state != EMPTY);
  assign full  = (state == TWO);
  assign pop   = valid && ready;
  assign dout  = head;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst || clear) state <= EMPTY;
    else               state <= state_next;
  end

  // The pop is resolved before the push: in TWO a pop frees the head slot,
  // the tail moves up and an incoming push lands in the tail.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_next     = state;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_next = TWO;
          load_tail  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          load_head      = 1'b1;
          head_from_tail = 1'b1;
          if (push) load_tail  = 1'b1;
          else      state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: the storage registers are reset as well as the state. The head
  // drives out_sum/out_bit directly, so it must read zero after reset/clear.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head) head <= head_from_tail ? tail : din;
      if (load_tail) tail <= din;
    end
  end

endmodule

// File: rtl/xnor_psum_accumulator.sv
// Accumulates NUM_CH signed partial sums from the XNOR PE array into one
// output-pixel sum. It binarizes the sum against a programmable threshold and
// queues {bit, sum} in a 2-entry buffer towards the next layer.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset (also clears thresh/inv)
//   in_valid   : in_psum valid this cycle
//   in_psum    : signed partial sum, legal range PSUM_MIN..PSUM_MAX
//   clear      : abort current pixel, flush buffer, clear overflow
//   thresh_wr  : load thresh_in / thresh_inv
//   thresh_in  : signed threshold
//   thresh_inv : invert binarized result
//   out_valid  : head entry valid
//   out_ready  : downstream accepts head entry
//   out_bit    : binarized activation of head entry
//   out_sum    : raw signed sum of head entry
//   ch_idx     : channels already accumulated for the current pixel
//   overflow   : sticky, a finished pixel was dropped on a full buffer
module xnor_psum_accumulator #(
  parameter int NUM_CH = 16,
  parameter int PSUM_W = bnn_pkg::PSUM_W,
  parameter int ACC_W  = PSUM_W + $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [PSUM_W-1:0]         in_psum,
  input  logic                      clear,
  input  logic                      thresh_wr,
  input  logic [ACC_W-1:0]          thresh_in,
  input  logic                      thresh_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_bit,
  output logic [ACC_W-1:0]          out_sum,
  output logic [$clog2(NUM_CH)-1:0] ch_idx,
  output logic                      overflow
);

  localparam int CH_W = $clog2(NUM_CH);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] thresh;
  logic                    inv;
  logic                    complete;
  logic                    result_bit;
  logic                    buf_full;
  logic [ACC_W:0]          buf_dout;

  assign psum_ext   = ACC_W'($signed(in_psum));
  assign sum        = acc + psum_ext;
  assign complete   = in_valid && (ch_idx == CH_W'(NUM_CH - 1));
  // thresh/inv are the registered values, so a thresh_wr landing on the
  // completion cycle still binarizes with the previous setting.
  assign result_bit = (sum >= thresh) ^ inv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      ch_idx   <= '0;
      overflow <= 1'b0;
      thresh   <= '0;
      inv      <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      ch_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (thresh_wr) begin
        thresh <= thresh_in;
        inv    <= thresh_inv;
      end
      if (complete) begin
        acc    <= '0;
        ch_idx <= '0;
      end else if (in_valid) begin
        acc    <= sum;
        ch_idx <= ch_idx + CH_W'(1);
      end
      // In TWO, out_valid is high, so a pop happens exactly when out_ready.
      if (complete && buf_full && !out_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && in_valid)
      assert (int'($signed(in_psum)) >= bnn_pkg::PSUM_MIN &&
              int'($signed(in_psum)) <= bnn_pkg::PSUM_MAX);
  end

  xnor_out_fifo #(
    .WIDTH (ACC_W + 1)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (complete),
    .din   ({result_bit, sum}),
    .ready (out_ready),
    .valid (out_valid),
    .full  (buf_full),
    .dout  (buf_dout)
  );

  assign out_bit = buf_dout[ACC_W];
  assign out_sum = buf_dout[ACC_W-1:0];

endmodule

// File: tb/tb_xnor_psum_accumulator.sv
// Directed bench for xnor_psum_accumulator with NUM_CH=16, ACC_W=9.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_xnor_psum_accumulator;

  localparam int NUM_CH = 16;
  localparam int PSUM_W = 5;
  localparam int ACC_W  = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [PSUM_W-1:0] in_psum;
  logic             clear;
  logic             thresh_wr;
  logic [ACC_W-1:0] thresh_in;
  logic             thresh_inv;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [ACC_W-1:0] out_sum;
  logic [3:0]       ch_idx;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xnor_psum_accumulator #(
    .NUM_CH (NUM_CH),
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_psum    (in_psum),
    .clear      (clear),
    .thresh_wr  (thresh_wr),
    .thresh_in  (thresh_in),
    .thresh_inv (thresh_inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_sum    (out_sum),
    .ch_idx     (ch_idx),
    .overflow   (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n back-to-back inputs of value v; in_valid drops afterwards.
  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_psum  = PSUM_W'(v);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic load_thresh(input int t, input logic iv);
    thresh_wr  = 1'b1;
    thresh_in  = ACC_W'(t);
    thresh_inv = iv;
    step();
    thresh_wr  = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_psum    = '0;
    clear      = 1'b0;
    thresh_wr  = 1'b0;
    thresh_in  = '0;
    thresh_inv = 1'b0;
    out_ready  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit",   out_bit,   0);
    chk("rst_out_sum",   $signed(out_sum), 0);
    chk("rst_ch_idx",    ch_idx,    0);
    chk("rst_overflow",  overflow,  0);

    // Sixteen +9 with thresh 0: sum 144, bit 1, one-cycle latency
    rst       = 1'b1;
    out_ready = 1'b1;
    feed(9, 15);
    chk("p9_ch_idx_15",   ch_idx,    15);
    chk("p9_not_yet",     out_valid, 0);
    feed(9, 1);
    chk("p9_valid",       out_valid, 1);
    chk("p9_sum",         $signed(out_sum), 144);
    chk("p9_bit",         out_bit,   1);
    chk("p9_ch_idx_wrap", ch_idx,    0);
    step();
    chk("p9_popped",      out_valid, 0);

    // Sixteen -9, thresh -144: equality counts as >=
    load_thresh(-144, 1'b0);
    feed(-9, 16);
    chk("m9_sum",     $signed(out_sum), -144);
    chk("m9_bit",     out_bit, 1);
    step();
    load_thresh(-144, 1'b1);
    feed(-9, 16);
    chk("m9_inv_sum", $signed(out_sum), -144);
    chk("m9_inv_bit", out_bit, 0);
    step();

    // Overflow: three pixels with the consumer stalled
    load_thresh(0, 1'b0);
    out_ready = 1'b0;
    feed(1, 16);
    feed(2, 16);
    chk("ovf_two_no_flag", overflow, 0);
    chk("ovf_two_head",    $signed(out_sum), 16);
    feed(3, 16);
    chk("ovf_flag",        overflow, 1);
    chk("ovf_head_kept",   $signed(out_sum), 16);
    out_ready = 1'b1;
    step();
    chk("ovf_second",      $signed(out_sum), 32);
    chk("ovf_second_v",    out_valid, 1);
    step();
    chk("ovf_drained",     out_valid, 0);
    chk("ovf_sticky",      overflow, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ovf_cleared",     overflow, 0);

    // Full buffer, completion and pop in the same cycle
    out_ready = 1'b0;
    feed(1, 16);
    feed(2, 16);
    feed(3, 15);
    in_valid  = 1'b1;
    in_psum   = PSUM_W'(3);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp_head",      $signed(out_sum), 32);
    chk("pp_valid",     out_valid, 1);
    chk("pp_no_drop",   overflow, 0);
    out_ready = 1'b1;
    step();
    chk("pp_third",     $signed(out_sum), 48);
    chk("pp_third_v",   out_valid, 1);
    step();
    chk("pp_empty",     out_valid, 0);

    // Threshold write coinciding with a completion uses the old threshold
    feed(3, 15);
    in_valid  = 1'b1;
    in_psum   = PSUM_W'(5);
    thresh_wr = 1'b1;
    thresh_in = ACC_W'(100);
    thresh_inv = 1'b0;
    step();
    in_valid  = 1'b0;
    thresh_wr = 1'b0;
    chk("tw_old_sum", $signed(out_sum), 50);
    chk("tw_old_bit", out_bit, 1);
    step();
    feed(3, 15);
    feed(5, 1);
    chk("tw_new_sum", $signed(out_sum), 50);
    chk("tw_new_bit", out_bit, 0);
    step();

    // clear mid-pixel discards the partial sum; in_valid that cycle ignored
    feed(5, 7);
    chk("clr_ch_idx_7", ch_idx, 7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_psum  = PSUM_W'(9);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_ch_idx_0", ch_idx, 0);
    feed(1, 16);
    chk("clr_sum",   $signed(out_sum), 16);
    chk("clr_bit",   out_bit, 0);
    chk("clr_valid", out_valid, 1);
    step();

    // rst mid-pixel also discards, and zeroes the threshold (100 -> 0)
    feed(5, 7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst2_ch_idx", ch_idx, 0);
    feed(1, 16);
    chk("rst2_sum",   $signed(out_sum), 16);
    chk("rst2_bit",   out_bit, 1);
    step();
    chk("rst2_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
